// File: rtl/ysyx_24090018_ifu_fetch_pkg.sv
// ysyx_24090018_ifu_fetch_pkg: shared types and constants for the instruction fetch unit
package ysyx_24090018_ifu_fetch_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_e;
  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_ACCESS   = 2'd2
  } fault_e;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
endpackage

// File: rtl/ysyx_24090018_ifu_fetch.sv
// ysyx_24090018_ifu_fetch: one-PC-at-a-time fetch with a single outstanding imem read.
//   pc_*        : PC handshake from the PC register
//   imem_req_*  : single-beat read request; imem_rsp_* : response, never backpressured
//   inst_*      : fetched instruction held for decode until inst_ready_i
//   flush_i     : cancels held and in-flight work; late responses are swallowed in DROP
module ysyx_24090018_ifu_fetch
  import ysyx_24090018_ifu_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_valid_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  output logic                  pc_ready_o,
  output logic                  imem_req_valid_o,
  output logic [ADDR_WIDTH-1:0] imem_req_addr_o,
  input  logic                  imem_req_ready_i,
  input  logic                  imem_rsp_valid_i,
  input  logic [INST_WIDTH-1:0] imem_rsp_data_i,
  input  logic                  imem_rsp_err_i,
  input  logic                  flush_i,
  output logic                  inst_valid_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o,
  output logic                  inst_err_o,
  input  logic                  inst_ready_i
);
  state_e                state;
  fault_e                cause;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [INST_WIDTH-1:0] inst_q;
  logic                  take;
  logic                  mis;
  assign pc_ready_o       = !flush_i && (state == S_IDLE || (state == S_HOLD && inst_ready_i));
  assign take             = pc_valid_i && pc_ready_o;
  assign mis              = pc_i[1:0] != 2'b00;
  assign imem_req_valid_o = state == S_REQ;
  assign imem_req_addr_o  = pc_q;
  assign inst_valid_o     = state == S_HOLD;
  assign inst_o           = inst_q;
  assign inst_pc_o        = pc_q;
  assign inst_err_o       = cause != FAULT_NONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pc_q   <= '0;
      inst_q <= '0;
      cause  <= FAULT_NONE;
    end else if (flush_i) begin
      // a request accepted this cycle, or one still awaiting its response, must be drained
      state <= ((state == S_REQ && imem_req_ready_i) ||
                ((state == S_WAIT || state == S_DROP) && !imem_rsp_valid_i)) ? S_DROP : S_IDLE;
    end else if (take) begin
      pc_q   <= pc_i;
      inst_q <= '0;
      cause  <= mis ? FAULT_MISALIGN : FAULT_NONE;
      state  <= mis ? S_HOLD : S_REQ;
    end else begin
      case (state)
        S_REQ:  if (imem_req_ready_i) state <= S_WAIT;
        S_WAIT: if (imem_rsp_valid_i) begin
          state  <= S_HOLD;
          inst_q <= imem_rsp_err_i ? '0 : imem_rsp_data_i;
          cause  <= imem_rsp_err_i ? FAULT_ACCESS : FAULT_NONE;
        end
        S_HOLD: if (inst_ready_i) state <= S_IDLE;
        S_DROP: if (imem_rsp_valid_i) state <= S_IDLE;
        default: ;
      endcase
    end
  end
  rsp_only_when_outstanding: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid_i |-> (state == S_WAIT || state == S_DROP));
endmodule

// File: tb/tb_ysyx_24090018_ifu_fetch.sv
// tb_ysyx_24090018_ifu_fetch: transaction-level model check of the fetch unit under directed and random traffic
module tb_ysyx_24090018_ifu_fetch;
  logic        clk = 1'b0;
  logic        rst;
  logic        pc_valid_i;
  logic [31:0] pc_i;
  logic        pc_ready_o;
  logic        imem_req_valid_o;
  logic [31:0] imem_req_addr_o;
  logic        imem_req_ready_i;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_err_i;
  logic        flush_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_err_o;
  logic        inst_ready_i;
  always #5 clk = ~clk;
  ysyx_24090018_ifu_fetch #(.ADDR_WIDTH(32), .INST_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .pc_valid_i(pc_valid_i), .pc_i(pc_i), .pc_ready_o(pc_ready_o),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_addr_o(imem_req_addr_o),
    .imem_req_ready_i(imem_req_ready_i),
    .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
    .imem_rsp_err_i(imem_rsp_err_i),
    .flush_i(flush_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_err_o(inst_err_o), .inst_ready_i(inst_ready_i)
  );
  int checks = 0;
  int errors = 0;
  // model: pending PC awaiting issue, live fetch in memory, any outstanding read, held instruction
  bit          m_pend, m_live, m_out, m_held, m_herr;
  logic [31:0] m_pc, m_hinst, m_hpc;
  int          mem_cnt = 0;
  int          mem_lat = 1;
  bit          mem_err_en = 1'b0;
  logic [31:0] mem_addr = '0;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 32'h8000_0000 ? 32'h0000_0413 : {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic bit exp_pc_ready();
    return !flush_i && !m_out && !m_pend && (!m_held || inst_ready_i);
  endfunction
  task automatic tick();
    bit take, acc, nout;
    @(negedge clk);
    chk("pc_ready", {31'd0, pc_ready_o}, {31'd0, exp_pc_ready()});
    chk("req_valid", {31'd0, imem_req_valid_o}, {31'd0, m_pend});
    if (m_pend) chk("req_addr", imem_req_addr_o, m_pc);
    chk("inst_valid", {31'd0, inst_valid_o}, {31'd0, m_held});
    if (m_held) begin
      chk("inst", inst_o, m_hinst);
      chk("inst_pc", inst_pc_o, m_hpc);
      chk("inst_err", {31'd0, inst_err_o}, {31'd0, m_herr});
    end
    take = pc_valid_i && exp_pc_ready();
    acc  = m_pend && imem_req_ready_i;
    if (rst) begin
      {m_pend, m_live, m_out, m_held} = '0;
      mem_cnt = 0;
    end else begin
      nout = imem_rsp_valid_i ? 1'b0 : (m_out || acc);
      if (flush_i) begin
        {m_pend, m_live, m_held} = '0;
      end else begin
        if (m_held && inst_ready_i) m_held = 1'b0;
        if (imem_rsp_valid_i && m_live) begin
          m_held  = 1'b1;
          m_herr  = imem_rsp_err_i;
          m_hinst = imem_rsp_err_i ? 32'd0 : mem_word(m_pc);
          m_hpc   = m_pc;
          m_live  = 1'b0;
        end
        if (acc) begin
          m_pend = 1'b0;
          m_live = 1'b1;
        end
        if (take) begin
          m_pc = pc_i;
          if (pc_i[1:0] != 2'b00) begin
            m_held  = 1'b1;
            m_herr  = 1'b1;
            m_hinst = 32'd0;
            m_hpc   = pc_i;
          end else m_pend = 1'b1;
        end
      end
      m_out = nout;
      if (imem_req_valid_o && imem_req_ready_i) begin
        mem_cnt  = mem_lat != 0 ? mem_lat : int'($urandom_range(1, 3));
        mem_addr = imem_req_addr_o;
      end
    end
    @(posedge clk);
    #1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_err_i   = 1'b0;
    imem_rsp_data_i  = $urandom;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = mem_word(mem_addr);
        imem_rsp_err_i   = mem_err_en && $urandom_range(0, 7) == 0;
      end
    end
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  initial begin
    {rst, pc_valid_i, imem_req_ready_i, imem_rsp_valid_i, imem_rsp_err_i, flush_i, inst_ready_i} = '0;
    pc_i = '0;
    imem_rsp_data_i = '0;
    {m_pend, m_live, m_out, m_held, m_herr} = '0;
    {m_pc, m_hinst, m_hpc} = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_inst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rst_req_valid", {31'd0, imem_req_valid_o}, 32'd0);
    chk("rst_req_addr", imem_req_addr_o, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_inst_pc", inst_pc_o, 32'd0);
    chk("rst_inst_err", {31'd0, inst_err_o}, 32'd0);
    chk("rst_pc_ready", {31'd0, pc_ready_o}, 32'd1);
    // minimum latency with a 1-cycle memory
    pc_valid_i = 1'b1; pc_i = 32'h8000_0000; imem_req_ready_i = 1'b1; inst_ready_i = 1'b1; mem_lat = 1;
    tick();
    pc_valid_i = 1'b0;
    tick();
    tick();
    chk("lat_inst_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("lat_inst", inst_o, 32'h0000_0413);
    chk("lat_inst_pc", inst_pc_o, 32'h8000_0000);
    tick();
    // back-to-back with decode stalled on the first
    inst_ready_i = 1'b0; pc_valid_i = 1'b1; pc_i = 32'h8000_0000;
    tick();
    pc_i = 32'h8000_0004;
    run(7);
    chk("stall_inst_pc", inst_pc_o, 32'h8000_0000);
    chk("stall_pc_ready", {31'd0, pc_ready_o}, 32'd0);
    chk("stall_req_valid", {31'd0, imem_req_valid_o}, 32'd0);
    inst_ready_i = 1'b1;
    tick();
    pc_i = 32'h8000_0008;
    run(3);
    pc_valid_i = 1'b0;
    run(4);
    // request backpressure
    pc_valid_i = 1'b1; pc_i = 32'h8000_0010; imem_req_ready_i = 1'b0;
    tick();
    pc_valid_i = 1'b0;
    run(4);
    chk("bp_req_valid", {31'd0, imem_req_valid_o}, 32'd1);
    chk("bp_req_addr", imem_req_addr_o, 32'h8000_0010);
    imem_req_ready_i = 1'b1;
    run(4);
    // misaligned PC
    pc_valid_i = 1'b1; pc_i = 32'h8000_0002; inst_ready_i = 1'b0;
    tick();
    pc_valid_i = 1'b0;
    chk("mis_inst_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("mis_err", {31'd0, inst_err_o}, 32'd1);
    chk("mis_inst", inst_o, 32'd0);
    chk("mis_req_valid", {31'd0, imem_req_valid_o}, 32'd0);
    inst_ready_i = 1'b1;
    tick();
    // flush while waiting, late response must be swallowed
    pc_valid_i = 1'b1; pc_i = 32'h8000_0020; mem_lat = 4;
    tick();
    pc_valid_i = 1'b0;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("drop_inst_valid", {31'd0, inst_valid_o}, 32'd0);
    end
    mem_lat = 1; pc_valid_i = 1'b1; pc_i = 32'h8000_0100; inst_ready_i = 1'b0;
    tick();
    pc_valid_i = 1'b0;
    run(2);
    chk("post_flush_pc", inst_pc_o, 32'h8000_0100);
    chk("post_flush_inst", inst_o, mem_word(32'h8000_0100));
    // reset while holding
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_hold_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rst_hold_ready", {31'd0, pc_ready_o}, 32'd1);
    // randomized traffic
    mem_lat = 0; mem_err_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      pc_valid_i       = $urandom_range(0, 9) < 7;
      pc_i             = {16'h8000, 14'($urandom_range(0, 16383)),
                          ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
      imem_req_ready_i = $urandom_range(0, 9) < 6;
      inst_ready_i     = $urandom_range(0, 9) < 6;
      flush_i          = $urandom_range(0, 19) == 0;
      rst              = $urandom_range(0, 299) == 0;
      tick();
    end
    {pc_valid_i, flush_i, rst} = '0;
    imem_req_ready_i = 1'b1;
    inst_ready_i = 1'b1;
    run(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
